// File: rtl/alu_op_issuer.sv
// alu_op_issuer: takes one VLIW action slot and the PHV container bank.
// It selects the ALU operands, issues them under the ALU ready handshake,
// then captures the returned container value and holds it until the
// downstream stage accepts it. Only one action is in flight at a time.
// Optional macro ALU_ISSUE_TIMEOUT_EN adds a WAIT-state watchdog. When it
// fires, op3 (the pass-through value) is returned and result_timeout is set.
module alu_op_issuer #(
    parameter int ACTION_LEN     = 64,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_CONT       = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [ACTION_LEN-1:0]          in_action,
    input  logic [NUM_CONT*DATA_WIDTH-1:0] in_phv,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [ACTION_LEN-1:0]          alu_action,
    output logic                           alu_action_valid,
    output logic [DATA_WIDTH-1:0]          alu_op1,
    output logic [DATA_WIDTH-1:0]          alu_op2,
    output logic [DATA_WIDTH-1:0]          alu_op3,
    output logic [DATA_WIDTH-1:0]          alu_op4,
    input  logic                           alu_ready_out,
    output logic                           alu_ready_in,
    input  logic [DATA_WIDTH-1:0]          alu_result,
    input  logic                           alu_result_valid,
    output logic [DATA_WIDTH-1:0]          result_data,
    output logic [2:0]                     result_dst,
    output logic                           result_valid,
    input  logic                           result_ready,
    output logic                           result_timeout
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

    state_t state;

    // The watchdog counter is 8 bits wide, so the limit must fit in that range
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("alu_op_issuer: TIMEOUT_CYCLES must be in 1..255");
    end

    // Split the flat bank into containers so a 3-bit index selects directly
    logic [NUM_CONT-1:0][DATA_WIDTH-1:0] cont;
    assign cont = in_phv;

    logic [7:0]  opcode;
    logic [2:0]  src1, src2, dst;
    logic [15:0] imm16;
    logic        use_imm;
    logic [DATA_WIDTH-1:0] op2_sel;

    assign opcode = in_action[63:56];
    assign src1   = in_action[55:53];
    assign src2   = in_action[52:50];
    assign dst    = in_action[49:47];
    assign imm16  = in_action[46:31];

    // Immediate-form opcodes take op2 from imm16; all others use container[src2]
    always_comb begin
        use_imm = 1'b0;
        case (opcode)
            8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0E: use_imm = 1'b1;
            default:                                 use_imm = 1'b0;
        endcase
        op2_sel = use_imm ? DATA_WIDTH'(imm16) : cont[src2];
    end

    // Handshake decodes depend only on the state register
    assign in_ready     = (state == IDLE);
    assign alu_ready_in = (state == WAIT);
    assign result_valid = (state == OUT);
    assign alu_op4      = '0;

`ifdef ALU_ISSUE_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wd_cnt;
`else
    assign result_timeout = 1'b0;
`endif

    // Issue FSM: latch the slot, issue once, collect the result, hold it for downstream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            alu_action       <= '0;
            alu_action_valid <= 1'b0;
            alu_op1          <= '0;
            alu_op2          <= '0;
            alu_op3          <= '0;
            result_data      <= '0;
            result_dst       <= '0;
`ifdef ALU_ISSUE_TIMEOUT_EN
            wd_cnt           <= '0;
            result_timeout   <= 1'b0;
`endif
        end else begin
            alu_action_valid <= 1'b0;
            case (state)
                IDLE: if (in_valid) begin
                    alu_action <= in_action;
                    alu_op1    <= cont[src1];
                    alu_op2    <= op2_sel;
                    alu_op3    <= cont[dst];
                    result_dst <= dst;
                    state      <= ISSUE;
                end
                ISSUE: if (alu_ready_out) begin
                    alu_action_valid <= 1'b1;
                    state            <= WAIT;
`ifdef ALU_ISSUE_TIMEOUT_EN
                    wd_cnt           <= '0;
`endif
                end
                WAIT: begin
                    if (alu_result_valid) begin
                        result_data <= alu_result;
                        state       <= OUT;
                    end
`ifdef ALU_ISSUE_TIMEOUT_EN
                    else if (wd_cnt == TO_LAST) begin
                        // ALU never answered: return the pass-through value
                        result_data    <= alu_op3;
                        result_timeout <= 1'b1;
                        state          <= OUT;
                    end else begin
                        wd_cnt <= wd_cnt + 8'd1;
                    end
`endif
                end
                OUT: if (result_ready) begin
                    state <= IDLE;
`ifdef ALU_ISSUE_TIMEOUT_EN
                    result_timeout <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_issuer.sv
// Directed bench for alu_op_issuer. A scoreboard of expected issues and
// results is built from the operand-selection rules, and a bench ALU model
// answers 2 cycles after each issue.
module tb_alu_op_issuer;

    logic         clk, rst_n;
    logic [63:0]  in_action;
    logic [255:0] in_phv;
    logic         in_valid, in_ready;
    logic [63:0]  alu_action;
    logic         alu_action_valid;
    logic [31:0]  alu_op1, alu_op2, alu_op3, alu_op4;
    logic         alu_ready_out, alu_ready_in;
    logic [31:0]  alu_result;
    logic         alu_result_valid;
    logic [31:0]  result_data;
    logic [2:0]   result_dst;
    logic         result_valid, result_ready, result_timeout;

    alu_op_issuer #(.ACTION_LEN(64), .DATA_WIDTH(32), .NUM_CONT(8), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_action(in_action), .in_phv(in_phv), .in_valid(in_valid), .in_ready(in_ready),
        .alu_action(alu_action), .alu_action_valid(alu_action_valid),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_op3(alu_op3), .alu_op4(alu_op4),
        .alu_ready_out(alu_ready_out), .alu_ready_in(alu_ready_in),
        .alu_result(alu_result), .alu_result_valid(alu_result_valid),
        .result_data(result_data), .result_dst(result_dst), .result_valid(result_valid),
        .result_ready(result_ready), .result_timeout(result_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] cont_of(input logic [255:0] p, input logic [2:0] i);
        return p[32*int'(i) +: 32];
    endfunction

    function automatic bit is_imm(input logic [7:0] op);
        return op inside {8'h09, 8'h0A, 8'h0E, 8'h08, 8'h0B, 8'h07};
    endfunction

    function automatic logic [31:0] m_op2(input logic [63:0] a, input logic [255:0] p);
        return is_imm(a[63:56]) ? {16'h0, a[46:31]} : cont_of(p, a[52:50]);
    endfunction

    // Bench ALU behaviour: add for 0x01 and immediate forms, xor-mix otherwise
    function automatic logic [31:0] f_alu(input logic [7:0] op, input logic [31:0] x,
                                          input logic [31:0] y, input logic [31:0] z);
        return (op == 8'h01 || is_imm(op)) ? x + y : x ^ y ^ z;
    endfunction

    function automatic logic [63:0] mk_act(input logic [7:0] op, input logic [2:0] s1,
                                           input logic [2:0] s2, input logic [2:0] d,
                                           input logic [15:0] imm);
        return {op, s1, s2, d, imm, 31'h0};
    endfunction

    typedef struct {
        logic [63:0] act;
        logic [31:0] o1, o2, o3;
        logic [2:0]  dst;
        logic [31:0] res;
        logic        to;
    } txn_t;

    txn_t iq[$];
    txn_t rq[$];
    bit   alu_mute;

    // Compare process: protocol exclusivity, issue contents and result contents
    always @(negedge clk) begin
        if (rst_n) begin
            txn_t t;
            chk("ready_decode_exclusive", 64'(int'(in_ready) + int'(alu_ready_in) + int'(result_valid) <= 1), 64'd1);
            if (in_valid && in_ready) begin
                t.act = in_action;
                t.o1  = cont_of(in_phv, in_action[55:53]);
                t.o2  = m_op2(in_action, in_phv);
                t.o3  = cont_of(in_phv, in_action[49:47]);
                t.dst = in_action[49:47];
                t.to  = alu_mute;
                t.res = alu_mute ? t.o3 : f_alu(in_action[63:56], t.o1, t.o2, t.o3);
                iq.push_back(t);
                rq.push_back(t);
            end
            if (alu_action_valid) begin
                if (iq.size() == 0) chk("unexpected_issue", 64'd1, 64'd0);
                else begin
                    t = iq.pop_front();
                    chk("issue_action", alu_action, t.act);
                    chk("issue_op1", 64'(alu_op1), 64'(t.o1));
                    chk("issue_op2", 64'(alu_op2), 64'(t.o2));
                    chk("issue_op3", 64'(alu_op3), 64'(t.o3));
                    chk("issue_op4", 64'(alu_op4), 64'd0);
                end
            end
            if (result_valid && result_ready) begin
                if (rq.size() == 0) chk("unexpected_result", 64'd1, 64'd0);
                else begin
                    t = rq.pop_front();
                    chk("result_data", 64'(result_data), 64'(t.res));
                    chk("result_dst", 64'(result_dst), 64'(t.dst));
                    chk("result_timeout", 64'(result_timeout), 64'(t.to));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    int          pend;
    logic [31:0] pend_res;
    logic [31:0] last_data;
    logic [2:0]  last_dst;
    logic        last_to;

    // One clock: step to just after the edge, then run the bench ALU
    task automatic tick();
        @(posedge clk);
        #1;
        alu_result_valid = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                alu_result_valid = 1'b1;
                alu_result       = pend_res;
            end
        end
        if (alu_action_valid && !alu_mute) begin
            pend     = 2;
            pend_res = f_alu(alu_action[63:56], alu_op1, alu_op2, alu_op3);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_alu_action"}, alu_action, 64'd0);
        chk({tag, "_action_valid"}, 64'(alu_action_valid), 64'd0);
        chk({tag, "_ops"}, {alu_op1 | alu_op2, alu_op3 | alu_op4}, 64'd0);
        chk({tag, "_alu_ready_in"}, 64'(alu_ready_in), 64'd0);
        chk({tag, "_result_data"}, 64'(result_data), 64'd0);
        chk({tag, "_result_dst"}, 64'(result_dst), 64'd0);
        chk({tag, "_result_valid"}, 64'(result_valid), 64'd0);
        chk({tag, "_result_timeout"}, 64'(result_timeout), 64'd0);
    endtask

    // Accept in cycle 0 (caller is in IDLE), stall issue/output as asked,
    // and check the result_valid latency, the single pulse and IDLE afterwards
    task automatic run_txn(input string nm, input logic [63:0] act, input logic [255:0] phv,
                           input int iss_stall, input int out_stall, input int exp_lat);
        int lat = -1;
        int pulses = 0;
        bit done = 0;
        logic [31:0] first = '0;
        chk({nm, "_idle_ready"}, 64'(in_ready), 64'd1);
        in_action = act;
        in_phv    = phv;
        in_valid  = 1'b1;
        for (int c = 1; c <= 40 && !done; c++) begin
            tick();
            in_valid      = 1'b0;
            alu_ready_out = (c > iss_stall);
            if (alu_action_valid) pulses++;
            if (result_valid) begin
                if (lat < 0) begin
                    lat       = c;
                    first     = result_data;
                    last_data = result_data;
                    last_dst  = result_dst;
                    last_to   = result_timeout;
                end else begin
                    chk({nm, "_out_stable"}, 64'(result_data), 64'(first));
                end
                if (c - lat < out_stall) begin
                    result_ready = 1'b0;
                    in_action    = act ^ 64'h1;
                    in_valid     = 1'b1;
                    chk({nm, "_out_in_ready"}, 64'(in_ready), 64'd0);
                end else begin
                    result_ready = 1'b1;
                    done         = 1;
                end
            end
        end
        chk({nm, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({nm, "_pulses"}, 64'(pulses), 64'd1);
        tick();
        result_ready = 1'b0;
        chk({nm, "_back_idle"}, 64'(in_ready), 64'd1);
    endtask

    logic [255:0] phv_a, phv_b, phv_c;
    logic [7:0]   ops [8] = '{8'h0A, 8'h0E, 8'h08, 8'h0B, 8'h07, 8'h02, 8'h0F, 8'h06};

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; alu_ready_out = 1'b0; result_ready = 1'b0;
        alu_result_valid = 1'b0; alu_result = '0; in_action = '0; in_phv = '0;
        pend = 0; pend_res = '0; alu_mute = 0;
        last_data = '0; last_dst = '0; last_to = 1'b0;
        for (int i = 0; i < 8; i++) begin
            phv_a[32*i +: 32] = 32'h100 + 32'(i) * 32'h11;
            phv_b[32*i +: 32] = 32'hA000_0000 | (32'(i) << 8) | 32'h3C;
            phv_c[32*i +: 32] = 32'h0;
        end
        phv_a[64 +: 32] = 32'd5;
        phv_a[96 +: 32] = 32'd7;
        phv_b[32 +: 32] = 32'h20;
        phv_c[160 +: 32] = 32'hDEADBEEF;

        #1 chk_reset("por");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Add: 5 + 7 -> 12 into container 4, result_valid in cycle 5
        run_txn("add", mk_act(8'h01, 3'd2, 3'd3, 3'd4, 16'h0), phv_a, 0, 0, 5);
        chk("add_op1_lit", 64'(alu_op1), 64'd5);
        chk("add_op2_lit", 64'(alu_op2), 64'd7);
        chk("add_res_lit", 64'(last_data), 64'd12);
        chk("add_dst_lit", 64'(last_dst), 64'd4);

        // Immediate op: op2 from imm16, container[src2] ignored
        run_txn("imm", mk_act(8'h09, 3'd1, 3'd3, 3'd2, 16'h0010), phv_b, 0, 0, 5);
        chk("imm_op2_lit", 64'(alu_op2), 64'h10);
        chk("imm_res_lit", 64'(last_data), 64'h30);

        // Opcode sweep for operand selection, back to back
        for (int k = 0; k < 8; k++)
            run_txn("sweep", mk_act(ops[k], 3'(k), 3'(7 - k), 3'((k + 3) % 8), 16'h1234 + 16'(k)),
                    phv_b, 0, 0, 5);

        // Issue backpressure: 3 stalled cycles
        run_txn("iss_bp", mk_act(8'h01, 3'd6, 3'd0, 3'd1, 16'h0), phv_a, 3, 0, 8);

        // Output backpressure: 4 stalled cycles with a competing request
        run_txn("out_bp", mk_act(8'h03, 3'd4, 3'd5, 3'd6, 16'h0), phv_a, 0, 4, 5);

        // Reset while in WAIT, then a late ALU strobe
        in_action = mk_act(8'h01, 3'd2, 3'd3, 3'd4, 16'h0);
        in_phv    = phv_a;
        in_valid  = 1'b1;
        tick(); in_valid = 1'b0; alu_ready_out = 1'b1;
        tick();
        tick();
        chk("rst_in_wait", 64'(alu_ready_in), 64'd1);
        #2 rst_n = 1'b0;
        #1 chk_reset("midrst");
        iq.delete(); rq.delete(); pend = 0;
        tick();
        rst_n = 1'b1;
        alu_result_valid = 1'b1;
        alu_result = 32'hBAD0BAD0;
        tick();
        chk("late_res_valid", 64'(result_valid), 64'd0);
        chk("late_res_data", 64'(result_data), 64'd0);
        chk("late_in_ready", 64'(in_ready), 64'd1);
        run_txn("post_rst", mk_act(8'h01, 3'd2, 3'd3, 3'd4, 16'h0), phv_a, 0, 0, 5);
        chk("post_rst_res", 64'(last_data), 64'd12);

`ifdef ALU_ISSUE_TIMEOUT_EN
        // Watchdog: silent ALU, 8 WAIT cycles (2..9), OUT in cycle 10
        alu_mute = 1;
        run_txn("wdog", mk_act(8'h01, 3'd0, 3'd1, 3'd5, 16'h0), phv_c, 0, 0, 10);
        chk("wdog_data_lit", 64'(last_data), 64'hDEADBEEF);
        chk("wdog_flag_lit", 64'(last_to), 64'd1);
        chk("wdog_flag_clr", 64'(result_timeout), 64'd0);
        alu_mute = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
